// File: rtl/sparse_decoder_pkg.sv
// Shared definitions for the sparse matrix decoder and its delta index accumulator.
// Contents: default index width, accumulator FSM state encoding, delta kind constants.
package sparse_decoder_pkg;

    localparam int unsigned DEFAULT_IDX_W = 32;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_RUN   = 2'd1,
        ACC_DRAIN = 2'd2
    } acc_state_e;

    // Value of delta_is_row for each delta kind
    localparam logic DELTA_COL = 1'b0;
    localparam logic DELTA_ROW = 1'b1;

endpackage

// File: rtl/delta_index_accumulator_if.sv
// Bus between the index-code decoder / SpMV consumer side (master) and the accumulator (slave).
// Signals: start/start_row/nnz control, busy/done/err status, delta stream in with
// stall_delta back-pressure, index pair stream out with stall_index back-pressure.
interface delta_index_accumulator_if
    import sparse_decoder_pkg::*;
#(
    parameter int unsigned IDX_W = DEFAULT_IDX_W
) ();

    logic             start;
    logic [IDX_W-1:0] start_row;
    logic [IDX_W-1:0] nnz;
    logic             busy;
    logic             done;
    logic             err;
    logic             push_delta;
    logic             delta_is_row;
    logic [IDX_W-1:0] delta;
    logic             stall_delta;
    logic             push_index;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             stall_index;

    modport master (
        output start, start_row, nnz, push_delta, delta_is_row, delta, stall_index,
        input  busy, done, err, stall_delta, push_index, row, col
    );

    modport slave (
        input  start, start_row, nnz, push_delta, delta_is_row, delta, stall_index,
        output busy, done, err, stall_delta, push_index, row, col
    );

endinterface

// File: rtl/index_fifo.sv
// Synchronous FIFO holding packed {row, col} index pairs.
// Ports: clk/rst_n, wr_en_i/wr_data_i write side, rd_en_i/rd_data_o read side (rd_data_o is
// the current head, valid while !empty_o), empty_o/full_o flags, count_o occupancy.
// Write while full is accepted only together with a read.
module index_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_ok, rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign rd_ok     = rd_en_i & ~empty_o;
    assign wr_ok     = wr_en_i & (~full_o | rd_ok);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/delta_index_accumulator.sv
// Turns the decoded column/row delta stream into absolute (row, col) index pairs for SpMV.
// Ports: clk, rst_n (async active-low), bus (slave modport) carrying start/nnz control,
// busy/done/err status, the delta input stream and the buffered index pair output stream.
module delta_index_accumulator
    import sparse_decoder_pkg::*;
#(
    parameter int unsigned IDX_W       = DEFAULT_IDX_W,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned STALL_SLACK = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    delta_index_accumulator_if.slave   bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    acc_state_e       state_q, state_d;
    logic [IDX_W-1:0] row_acc_q, row_acc_d;
    logic [IDX_W-1:0] col_acc_q, col_acc_d;
    logic [IDX_W-1:0] remaining_q, remaining_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;
    logic             err_set;

    logic             fifo_empty, fifo_full, pop, wr_en;
    logic [CW-1:0]    fifo_count, count_next;
    logic [2*IDX_W-1:0] head;

    logic             col_push, row_push;
    logic [IDX_W:0]   col_sum, row_sum;
    logic [IDX_W-1:0] col_new;

    assign pop      = ~fifo_empty & ~bus.stall_index;
    assign col_push = (state_q == ACC_RUN) & bus.push_delta & (bus.delta_is_row == DELTA_COL);
    assign row_push = (state_q == ACC_RUN) & bus.push_delta & (bus.delta_is_row == DELTA_ROW);
    // A column delta is dropped only when the FIFO is full and nothing leaves this cycle
    assign wr_en    = col_push & (~fifo_full | pop);
    assign col_sum  = {1'b0, col_acc_q} + {1'b0, bus.delta};
    assign row_sum  = {1'b0, row_acc_q} + {1'b0, bus.delta};
    assign col_new  = first_q ? bus.delta : col_sum[IDX_W-1:0];

    index_fifo #(
        .WIDTH (2 * IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i ({row_acc_q, col_new}),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        row_acc_d   = row_acc_q;
        col_acc_d   = col_acc_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        err_d       = err_q;
        err_set     = 1'b0;
        unique case (state_q)
            ACC_IDLE: begin
                if (bus.push_delta) err_set = 1'b1;
                if (bus.start) begin
                    row_acc_d   = bus.start_row;
                    col_acc_d   = '0;
                    first_d     = 1'b1;
                    remaining_d = bus.nnz;
                    err_d       = 1'b0;
                    state_d     = (bus.nnz == '0) ? ACC_DRAIN : ACC_RUN;
                end
            end
            ACC_RUN: begin
                if (row_push) begin
                    row_acc_d = row_sum[IDX_W-1:0];
                    col_acc_d = '0;
                    first_d   = 1'b1;
                    if (row_sum[IDX_W]) err_set = 1'b1;
                end else if (col_push) begin
                    if (wr_en) begin
                        col_acc_d   = col_new;
                        first_d     = 1'b0;
                        remaining_d = remaining_q - IDX_W'(1);
                        // Carry out or duplicate column only apply to relative deltas
                        if (!first_q && (col_sum[IDX_W] || bus.delta == '0)) err_set = 1'b1;
                        if (remaining_q == IDX_W'(1)) state_d = ACC_DRAIN;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ACC_DRAIN: begin
                if (bus.push_delta) err_set = 1'b1;
                if (fifo_empty) state_d = ACC_IDLE;
            end
            default: state_d = ACC_IDLE;
        endcase
        err_d = err_d | err_set;
    end

    // Registered from next-cycle occupancy so stall_delta tracks the current fill level
    assign count_next = fifo_count + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, pop};
    assign stall_d    = (CW'(FIFO_DEPTH) - count_next) <= CW'(STALL_SLACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC_IDLE;
            row_acc_q   <= '0;
            col_acc_q   <= '0;
            remaining_q <= '0;
            first_q     <= 1'b1;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_acc_q   <= row_acc_d;
            col_acc_q   <= col_acc_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.busy        = (state_q != ACC_IDLE);
    assign bus.done        = (state_q == ACC_DRAIN) & fifo_empty;
    assign bus.err         = err_q;
    assign bus.stall_delta = stall_q;
    assign bus.push_index  = pop;
    assign bus.row         = head[2*IDX_W-1:IDX_W];
    assign bus.col         = head[IDX_W-1:0];

endmodule

// File: tb/tb_delta_index_accumulator.sv
// Directed self-checking bench for delta_index_accumulator.
module tb_delta_index_accumulator;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    delta_index_accumulator_if bus ();

    delta_index_accumulator u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_push();
        bus.push_delta   = 1'b0;
        bus.delta_is_row = 1'b0;
        bus.delta        = '0;
    endtask

    task automatic push_col(input logic [31:0] d);
        bus.push_delta   = 1'b1;
        bus.delta_is_row = 1'b0;
        bus.delta        = d;
    endtask

    task automatic push_row(input logic [31:0] d);
        bus.push_delta   = 1'b1;
        bus.delta_is_row = 1'b1;
        bus.delta        = d;
    endtask

    task automatic do_start(input logic [31:0] r, input logic [31:0] n);
        bus.start     = 1'b1;
        bus.start_row = r;
        bus.nnz       = n;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.start_row = '0; bus.nnz = '0; bus.stall_index = 1'b0;
        no_push();
        #12;
        total_cnt++;
        if ({bus.busy, bus.done, bus.err, bus.stall_delta, bus.push_index, bus.row, bus.col}
            !== {5'b0, 32'd0, 32'd0})
            $display("FAIL reset_outputs got b%0b d%0b e%0b s%0b p%0b r%0d c%0d exp all 0",
                     bus.busy, bus.done, bus.err, bus.stall_delta, bus.push_index,
                     bus.row, bus.col);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_start(32'd5, 32'd3);
        push_col(32'd2); #1;
        total_cnt++;
        if ({bus.busy, bus.push_index} !== 2'b10)
            $display("FAIL t1_first got busy/push %b exp 10", {bus.busy, bus.push_index});
        else pass_cnt++;
        tick(); push_col(32'd3); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col} !== {1'b1, 32'd5, 32'd2})
            $display("FAIL t1_pair0 got p%0b (%0d,%0d) exp (5,2)", bus.push_index, bus.row, bus.col);
        else pass_cnt++;
        tick(); push_col(32'd1); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col} !== {1'b1, 32'd5, 32'd5})
            $display("FAIL t1_pair1 got p%0b (%0d,%0d) exp (5,5)", bus.push_index, bus.row, bus.col);
        else pass_cnt++;
        tick(); no_push(); #1;
        total_cnt++;
        if ({bus.push_index, bus.done, bus.row, bus.col} !== {2'b10, 32'd5, 32'd6})
            $display("FAIL t1_pair2 got p%0b d%0b (%0d,%0d) exp p1 d0 (5,6)",
                     bus.push_index, bus.done, bus.row, bus.col);
        else pass_cnt++;
        tick(); #1;
        total_cnt++;
        if ({bus.push_index, bus.done, bus.busy} !== 3'b011)
            $display("FAIL t1_done got p/d/b %b exp 011", {bus.push_index, bus.done, bus.busy});
        else pass_cnt++;
        tick(); #1;
        total_cnt++;
        if ({bus.done, bus.busy, bus.err} !== 3'b000)
            $display("FAIL t1_idle got d/b/e %b exp 000", {bus.done, bus.busy, bus.err});
        else pass_cnt++;
    endtask

    task automatic test_row_delta();
        do_start(32'd0, 32'd2);
        push_col(32'd4);
        tick(); push_row(32'd2); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col} !== {1'b1, 32'd0, 32'd4})
            $display("FAIL t2_pair0 got p%0b (%0d,%0d) exp (0,4)", bus.push_index, bus.row, bus.col);
        else pass_cnt++;
        tick(); push_col(32'd7); #1;
        total_cnt++;
        if (bus.push_index !== 1'b0)
            $display("FAIL t2_row_no_write got %b exp 0", bus.push_index);
        else pass_cnt++;
        tick(); no_push(); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col, bus.err} !== {1'b1, 32'd2, 32'd7, 1'b0})
            $display("FAIL t2_pair1 got p%0b (%0d,%0d) e%0b exp (2,7) e0",
                     bus.push_index, bus.row, bus.col, bus.err);
        else pass_cnt++;
        tick(); #1;
        total_cnt++;
        if ({bus.done, bus.err} !== 2'b10)
            $display("FAIL t2_done got d/e %b exp 10", {bus.done, bus.err});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        int  sent;
        int  got;
        bit  pushed;
        bit  seen_done;
        int  stall_errs;
        sent = 0; got = 0; seen_done = 0; stall_errs = 0;
        bus.stall_index = 1'b1;
        do_start(32'd0, 32'd8);
        for (int i = 0; i < 20; i++) begin
            total_cnt++;
            if ({bus.stall_delta, bus.push_index} !== {((8 - sent) <= 2), 1'b0}) begin
                $display("FAIL t3_stall occ %0d got s%0b p%0b exp s%0b p0",
                         sent, bus.stall_delta, bus.push_index, ((8 - sent) <= 2));
            end else pass_cnt++;
            pushed = (!bus.stall_delta && sent < 8);
            if (pushed) push_col(32'd1); else no_push();
            tick();
            if (pushed) sent++;
        end
        no_push();
        total_cnt++;
        if (sent !== 6) $display("FAIL t3_held got %0d pushes exp 6", sent);
        else pass_cnt++;
        bus.stall_index = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            pushed = (!bus.stall_delta && sent < 8);
            if (pushed) push_col(32'd1); else no_push();
            #1;
            if (bus.push_index) begin
                total_cnt++;
                if ({bus.row, bus.col} !== {32'd0, 32'(got + 1)})
                    $display("FAIL t3_order idx %0d got (%0d,%0d) exp (0,%0d)",
                             got, bus.row, bus.col, got + 1);
                else pass_cnt++;
                got++;
            end
            if (bus.done) seen_done = 1;
            tick();
            if (pushed) sent++;
        end
        no_push();
        total_cnt++;
        if ({got, 31'd0, seen_done, bus.err} !== {32'd8, 31'd0, 1'b1, 1'b0})
            $display("FAIL t3_complete got %0d pairs done %0b err %0b exp 8 1 0",
                     got, seen_done, bus.err);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_start(32'd3, 32'd2);
        push_col(32'hFFFF_FFFE);
        tick(); push_col(32'd3); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col, bus.err} !== {1'b1, 32'd3, 32'hFFFF_FFFE, 1'b0})
            $display("FAIL t4_pair0 got p%0b (%0d,%0h) e%0b exp (3,fffffffe) e0",
                     bus.push_index, bus.row, bus.col, bus.err);
        else pass_cnt++;
        tick(); no_push(); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col, bus.err} !== {1'b1, 32'd3, 32'd1, 1'b1})
            $display("FAIL t4_wrap got p%0b (%0d,%0h) e%0b exp (3,1) e1",
                     bus.push_index, bus.row, bus.col, bus.err);
        else pass_cnt++;
        tick(); #1;
        total_cnt++;
        if ({bus.done, bus.err} !== 2'b11)
            $display("FAIL t4_sticky got d/e %b exp 11", {bus.done, bus.err});
        else pass_cnt++;
        tick();
        do_start(32'd1, 32'd1); #1;
        total_cnt++;
        if ({bus.busy, bus.err} !== 2'b10)
            $display("FAIL t4_clear got b/e %b exp 10", {bus.busy, bus.err});
        else pass_cnt++;
        push_col(32'd9);
        tick(); no_push(); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col} !== {1'b1, 32'd1, 32'd9})
            $display("FAIL t4_restart got p%0b (%0d,%0d) exp (1,9)", bus.push_index, bus.row, bus.col);
        else pass_cnt++;
        tick(); tick();
    endtask

    task automatic test_empty_and_idle_push();
        do_start(32'd4, 32'd0); #1;
        total_cnt++;
        if ({bus.busy, bus.done, bus.push_index} !== 3'b110)
            $display("FAIL t5_drain got b/d/p %b exp 110", {bus.busy, bus.done, bus.push_index});
        else pass_cnt++;
        tick(); #1;
        total_cnt++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000)
            $display("FAIL t5_idle got b/d/e %b exp 000", {bus.busy, bus.done, bus.err});
        else pass_cnt++;
        push_col(32'd5);
        tick(); no_push(); #1;
        total_cnt++;
        if ({bus.err, bus.push_index, bus.busy} !== 3'b100)
            $display("FAIL t5_idle_push got e/p/b %b exp 100", {bus.err, bus.push_index, bus.busy});
        else pass_cnt++;
        tick(); #1;
        total_cnt++;
        if (bus.push_index !== 1'b0) $display("FAIL t5_no_out got %b exp 0", bus.push_index);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        bus.stall_index = 1'b1;
        do_start(32'd7, 32'd8);
        for (int i = 0; i < 4; i++) begin
            push_col(32'd1);
            tick();
        end
        no_push();
        bus.stall_index = 1'b0; #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col} !== {1'b1, 32'd7, 32'd1})
            $display("FAIL t6_queued got p%0b (%0d,%0d) exp (7,1)", bus.push_index, bus.row, bus.col);
        else pass_cnt++;
        rst_n = 1'b0; #1;
        total_cnt++;
        if ({bus.push_index, bus.busy, bus.done, bus.stall_delta, bus.row, bus.col}
            !== {4'b0, 32'd0, 32'd0})
            $display("FAIL t6_async got p%0b b%0b d%0b s%0b (%0d,%0d) exp all 0",
                     bus.push_index, bus.busy, bus.done, bus.stall_delta, bus.row, bus.col);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if ({bus.done, bus.busy, bus.push_index} !== 3'b000)
                $display("FAIL t6_held got d/b/p %b exp 000", {bus.done, bus.busy, bus.push_index});
            else pass_cnt++;
        end
        rst_n = 1'b1;
        tick();
        do_start(32'd2, 32'd1);
        push_col(32'd5);
        tick(); no_push(); #1;
        total_cnt++;
        if ({bus.push_index, bus.row, bus.col} !== {1'b1, 32'd2, 32'd5})
            $display("FAIL t6_restart got p%0b (%0d,%0d) exp (2,5)", bus.push_index, bus.row, bus.col);
        else pass_cnt++;
        tick(); #1;
        total_cnt++;
        if ({bus.done, bus.err} !== 2'b10)
            $display("FAIL t6_done got d/e %b exp 10", {bus.done, bus.err});
        else pass_cnt++;
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_row_delta();
        test_stall();
        test_overflow();
        test_empty_and_idle_push();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
